// File: rtl/camera_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : camera_init_sequencer
// Brief    : Sensor power-down exit, hardware reset, I2C config request with
//            bounded retry, then capture enable; latches a fault when retries
//            are exhausted.
// Revision : 1.0 - initial release
// ============================================================================
module camera_init_sequencer #(
    parameter int T_PWR     = 1000,
    parameter int T_SETTLE  = 5000,
    parameter int T_CFG_TO  = 1000000,
    parameter int MAX_RETRY = 3
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iREADY,
    input  logic       iCFG_DONE,
    input  logic       iCFG_ERR,
    output logic       oSENSOR_PWDN,
    output logic       oSENSOR_RSTn,
    output logic       oCFG_START,
    output logic       oCAP_EN,
    output logic       oERR,
    output logic [2:0] oSTATE
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PWR    = 3'd1,
        SETTLE = 3'd2,
        REQ    = 3'd3,
        WAIT   = 3'd4,
        RUN    = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam logic [31:0] c_PWR_LAST    = 32'(T_PWR - 1);
    localparam logic [31:0] c_SETTLE_LAST = 32'(T_SETTLE - 1);
    localparam logic [31:0] c_TO_LAST     = 32'(T_CFG_TO - 1);
    localparam logic [2:0]  c_MAX_RETRY   = 3'(MAX_RETRY);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_cycleCnt;
    logic [2:0]  r_retryCnt;
    logic [2:0]  w_retryInc;
    logic        w_fail;

    assign w_retryInc = r_retryCnt + 3'd1;
    assign oSTATE     = r_state;

    always_comb begin
        w_nextState = r_state;
        w_fail      = 1'b0;
        case (r_state)
            IDLE:   if (iREADY) w_nextState = PWR;
            PWR:    if (r_cycleCnt == c_PWR_LAST) w_nextState = SETTLE;
            SETTLE: if (r_cycleCnt == c_SETTLE_LAST) w_nextState = REQ;
            REQ:    w_nextState = WAIT;
            WAIT: begin
                // Error beats done; done on the final timeout cycle still succeeds.
                if (iCFG_ERR || (!iCFG_DONE && r_cycleCnt == c_TO_LAST)) begin
                    w_fail      = 1'b1;
                    w_nextState = (w_retryInc < c_MAX_RETRY) ? PWR : FAULT;
                end else if (iCFG_DONE) begin
                    w_nextState = RUN;
                end
            end
            RUN:     w_nextState = RUN;
            FAULT:   w_nextState = FAULT;
            default: w_nextState = IDLE;
        endcase
        if (r_state != IDLE && !iREADY) w_nextState = IDLE;
    end

    // Outputs are decoded from the next state so they move with oSTATE.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state      <= IDLE;
            r_cycleCnt   <= 32'd0;
            r_retryCnt   <= 3'd0;
            oSENSOR_PWDN <= 1'b1;
            oSENSOR_RSTn <= 1'b0;
            oCFG_START   <= 1'b0;
            oCAP_EN      <= 1'b0;
            oERR         <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_cycleCnt <= (w_nextState != r_state) ? 32'd0 : r_cycleCnt + 32'd1;

            if (w_nextState == IDLE || w_nextState == RUN)
                r_retryCnt <= 3'd0;
            else if (w_fail)
                r_retryCnt <= w_retryInc;

            oSENSOR_PWDN <= 1'b0;
            oSENSOR_RSTn <= 1'b1;
            oCFG_START   <= 1'b0;
            oCAP_EN      <= 1'b0;
            oERR         <= 1'b0;
            case (w_nextState)
                IDLE: begin
                    oSENSOR_PWDN <= 1'b1;
                    oSENSOR_RSTn <= 1'b0;
                end
                PWR:   oSENSOR_RSTn <= 1'b0;
                REQ:   oCFG_START   <= 1'b1;
                RUN:   oCAP_EN      <= 1'b1;
                FAULT: begin
                    oSENSOR_PWDN <= 1'b1;
                    oSENSOR_RSTn <= 1'b0;
                    oERR         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
